// File: rtl/huffman_bit_packer_if.sv
// Stream bundle for the Huffman bit packer: code beats in, packed words out.
// slave modport is the packer side, master modport is the source/sink side.
interface huffman_bit_packer_if #(
    parameter int CODE_W = 32,
    parameter int LEN_W  = 6,
    parameter int OUT_W  = 128
);
    localparam int TB_W = $clog2(OUT_W) + 1;

    logic [CODE_W-1:0] s_axis_tcode;
    logic [LEN_W-1:0]  s_axis_tlen;
    logic              s_axis_tlast;
    logic              s_axis_tvalid;
    logic              s_axis_tready;

    logic [OUT_W-1:0]  m_axis_tdata;
    logic [TB_W-1:0]   m_axis_tbits;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;

    modport slave (
        input  s_axis_tcode, s_axis_tlen, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tbits, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tcode, s_axis_tlen, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tbits, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/huffman_bit_packer.sv
// Packs variable-length codes MSB-first into OUT_W-bit words, flushing on tlast.
// Define HUFF_PACK_STATS_EN to add per-block bit/symbol statistics outputs.
module huffman_bit_packer #(
    parameter int CODE_W = 32,
    parameter int LEN_W  = 6,
    parameter int OUT_W  = 128
) (
    input  logic aclk,
    input  logic aresetn,
`ifdef HUFF_PACK_STATS_EN
    output logic [31:0] stat_bits,
    output logic [31:0] stat_syms,
`endif
    huffman_bit_packer_if.slave axis
);
    localparam int BW    = OUT_W + CODE_W;
    localparam int CNT_W = $clog2(BW + 1);
    localparam int TB_W  = $clog2(OUT_W) + 1;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              mv_q, mv_d;
    logic              ml_q, ml_d;
    logic [OUT_W-1:0]  md_q, md_d;
    logic [TB_W-1:0]   mb_q, mb_d;

    logic [LEN_W-1:0]  len_c;
    logic [CODE_W-1:0] code_c;
    logic [CNT_W-1:0]  sh_c, ca_c;
    logic [BW-1:0]     bufa_c;
    logic              acc_c, fl_c, can_c, hs_last_c;

    assign acc_c     = rdy_q && axis.s_axis_tvalid;
    assign can_c     = !mv_q || axis.m_axis_tready;
    assign hs_last_c = mv_q && ml_q && axis.m_axis_tready;

    always_comb begin
        len_c  = (axis.s_axis_tlen > LEN_W'(CODE_W)) ? LEN_W'(CODE_W)
                                                     : axis.s_axis_tlen;
        code_c = axis.s_axis_tcode & ~({CODE_W{1'b1}} << len_c);
        sh_c   = CNT_W'(BW) - cnt_q - CNT_W'(len_c);
        bufa_c = buf_q;
        ca_c   = cnt_q;
        // Append first, then emit from the combined buffer: no fill bubble
        if (acc_c) begin
            bufa_c = buf_q | (BW'(code_c) << sh_c);
            ca_c   = cnt_q + CNT_W'(len_c);
        end
        fl_c = (state_q == FLUSH) || (acc_c && axis.s_axis_tlast);

        state_d = fl_c ? FLUSH : RUN;
        buf_d   = bufa_c;
        cnt_d   = ca_c;
        mv_d    = mv_q && !axis.m_axis_tready;
        ml_d    = ml_q;
        md_d    = md_q;
        mb_d    = mb_q;

        if (state_q == FLUSH && mv_q && ml_q) begin
            if (axis.m_axis_tready) begin
                state_d = RUN;
                ml_d    = 1'b0;
            end
        end else if (can_c) begin
            if (ca_c >= CNT_W'(OUT_W)) begin
                md_d  = bufa_c[BW-1 -: OUT_W];
                mb_d  = TB_W'(OUT_W);
                ml_d  = fl_c && (ca_c == CNT_W'(OUT_W));
                mv_d  = 1'b1;
                buf_d = bufa_c << OUT_W;
                cnt_d = ca_c - CNT_W'(OUT_W);
            end else if (fl_c) begin
                md_d  = bufa_c[BW-1 -: OUT_W];
                mb_d  = TB_W'(ca_c);
                ml_d  = 1'b1;
                mv_d  = 1'b1;
                buf_d = '0;
                cnt_d = '0;
            end
        end

        rdy_d = (state_d == RUN) && (cnt_d < CNT_W'(OUT_W));
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= RUN;
            buf_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            mv_q    <= 1'b0;
            ml_q    <= 1'b0;
            md_q    <= '0;
            mb_q    <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            mv_q    <= mv_d;
            ml_q    <= ml_d;
            md_q    <= md_d;
            mb_q    <= mb_d;
        end
    end

    assign axis.s_axis_tready = rdy_q;
    assign axis.m_axis_tdata  = md_q;
    assign axis.m_axis_tbits  = mb_q;
    assign axis.m_axis_tlast  = ml_q;
    assign axis.m_axis_tvalid = mv_q;

`ifdef HUFF_PACK_STATS_EN
    logic [31:0] blk_bits_q, blk_syms_q, st_bits_q, st_syms_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            blk_bits_q <= '0;
            blk_syms_q <= '0;
            st_bits_q  <= '0;
            st_syms_q  <= '0;
        end else if (hs_last_c) begin
            st_bits_q  <= blk_bits_q;
            st_syms_q  <= blk_syms_q;
            blk_bits_q <= '0;
            blk_syms_q <= '0;
        end else if (acc_c) begin
            blk_bits_q <= blk_bits_q + 32'(len_c);
            blk_syms_q <= blk_syms_q + 32'd1;
        end
    end

    assign stat_bits = st_bits_q;
    assign stat_syms = st_syms_q;
`endif
endmodule
